// File: rtl/mem_resp_pkg.sv
// Shared widths and the response-stage payload for the memory read responder.
package mem_resp_pkg;

   localparam int unsigned MAX_LATENCY = 8;
   localparam int unsigned WORD_W      = 16;
   localparam int unsigned ADDR_W      = 16;
   localparam int unsigned CNT_W       = 4;

   typedef struct packed {
      logic              valid;
      logic [WORD_W-1:0] data;
      logic              oor;
   } resp_stage_t;

endpackage

// File: rtl/mem_resp_stage.sv
// One response pipeline register; the whole payload clears asynchronously so
// an empty stage always carries zero data.
module mem_resp_stage
   import mem_resp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  resp_stage_t d,
   output resp_stage_t q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_read_responder.sv
// Fixed-latency word memory: writes update the array, reads return in order
// LATENCY cycles later. Define MEM_RESP_OOR_EN for out-of-range detection (oor_err).
module mem_read_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned DEPTH_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] data_in,
   output logic [WORD_W-1:0] data_out,
   output logic              data_valid,
`ifdef MEM_RESP_OOR_EN
   output logic              oor_err,
`endif
   output logic [CNT_W-1:0]  inflight
);

   localparam int unsigned DEPTH = 1 << DEPTH_W;

   if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("mem_read_responder: LATENCY out of range");
   end

   logic [WORD_W-1:0]  mem [DEPTH];
   logic [DEPTH_W-1:0] word_c;
   logic               oor_c;
   logic               rd_c;
   logic               wr_c;
   logic               unused_c;
   resp_stage_t        stage0_c;
   resp_stage_t        pipe_q [LATENCY];

   assign word_c = addr[DEPTH_W:1];

`ifdef MEM_RESP_OOR_EN
   assign oor_c = |(addr >> (DEPTH_W + 1));
`else
   assign oor_c = 1'b0;
`endif

   // Requests only count while out of reset; out-of-range writes are dropped.
   assign rd_c = rst_n & enable & ~wr;
   assign wr_c = rst_n & enable & wr & ~oor_c;

   // Array contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_c) begin
         mem[word_c] <= data_in;
      end
   end

   always_comb begin
      stage0_c = '0;
      if (rd_c) begin
         stage0_c.valid = 1'b1;
         stage0_c.oor   = oor_c;
         stage0_c.data  = oor_c ? '0 : mem[word_c];
      end
   end

   for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      if (i == 0) begin : g_first
         mem_resp_stage u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (stage0_c),
            .q     (pipe_q[i])
         );
      end else begin : g_next
         mem_resp_stage u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (pipe_q[i-1]),
            .q     (pipe_q[i])
         );
      end
   end

   assign data_valid = pipe_q[LATENCY-1].valid;
   assign data_out   = pipe_q[LATENCY-1].data;
`ifdef MEM_RESP_OOR_EN
   assign oor_err    = pipe_q[LATENCY-1].oor;
`endif

   // Byte-select bit is ignored; upper bits only matter with range checking.
   assign unused_c = ^{addr, pipe_q[LATENCY-1].oor};

   // Outstanding reads: +1 on accept, -1 on return, unchanged when both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
      end else if (rd_c && !data_valid) begin
         inflight <= inflight + CNT_W'(1);
      end else if (!rd_c && data_valid) begin
         inflight <= inflight - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_read_responder.sv
// Self-checking bench: LATENCY=4 and LATENCY=1 instances share stimulus and
// are compared every cycle against a cycle-indexed response schedule.
module tb_mem_read_responder;

   localparam int unsigned DW   = 12;
   localparam int unsigned RING = 64;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b1;
   logic        enable  = 1'b0;
   logic        wr      = 1'b0;
   logic [15:0] addr    = '0;
   logic [15:0] data_in = '0;

   logic [15:0] dout4, dout1;
   logic        dv4, dv1;
   logic [3:0]  inf4, inf1;
`ifdef MEM_RESP_OOR_EN
   logic        oor4, oor1;
`endif

   int checks = 0;
   int passes = 0;
   int unsigned cyc = 0;

   logic [15:0] mem_m [4096];
   bit          rd_hist [RING];
   bit          exp_v [2][RING];
   logic [15:0] exp_d [2][RING];
   bit          exp_o [2][RING];

   always #5 clk = ~clk;

   mem_read_responder #(.LATENCY(4), .DEPTH_W(DW)) u_dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .wr         (wr),
      .addr       (addr),
      .data_in    (data_in),
      .data_out   (dout4),
      .data_valid (dv4),
`ifdef MEM_RESP_OOR_EN
      .oor_err    (oor4),
`endif
      .inflight   (inf4)
   );

   mem_read_responder #(.LATENCY(1), .DEPTH_W(DW)) u_dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .wr         (wr),
      .addr       (addr),
      .data_in    (data_in),
      .data_out   (dout1),
      .data_valid (dv1),
`ifdef MEM_RESP_OOR_EN
      .oor_err    (oor1),
`endif
      .inflight   (inf1)
   );

   function automatic int unsigned lat_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic bit is_oor(input logic [15:0] a);
`ifdef MEM_RESP_OOR_EN
      return (int'(a) >> (DW + 1)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int unsigned word_of(input logic [15:0] a);
      return (int'(a) / 2) % 4096;
   endfunction

   task automatic check(input string name, input int inst, input logic [15:0] got,
                        input logic [15:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, inst, cyc, got, want);
   endtask

   // Reference: on every sampling edge, schedule the response for cycle n+LATENCY.
   initial begin
      int unsigned slot;
      int unsigned s;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            for (int r = 0; r < RING; r++) begin
               rd_hist[r] = 1'b0;
               exp_v[0][r] = 1'b0;
               exp_v[1][r] = 1'b0;
            end
         end else begin
            slot = cyc % RING;
            rd_hist[slot] = enable && !wr;
            exp_v[0][slot] = 1'b0;
            exp_v[1][slot] = 1'b0;
            if (enable) begin
               if (wr) begin
                  if (!is_oor(addr)) mem_m[word_of(addr)] = data_in;
               end else begin
                  for (int i = 0; i < 2; i++) begin
                     s = (cyc + lat_of(i)) % RING;
                     exp_v[i][s] = 1'b1;
                     exp_d[i][s] = is_oor(addr) ? 16'h0000 : mem_m[word_of(addr)];
                     exp_o[i][s] = is_oor(addr);
                  end
               end
            end
         end
         cyc++;
      end
   end

   // Every cycle, mid-cycle: compare both instances against the schedule.
   initial begin
      bit          ev, eo;
      logic [15:0] ed;
      int unsigned ei;
      logic        gdv, goo;
      logic [15:0] gdo;
      logic [3:0]  gin;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            gdv = (i == 0) ? dv4 : dv1;
            gdo = (i == 0) ? dout4 : dout1;
            gin = (i == 0) ? inf4 : inf1;
`ifdef MEM_RESP_OOR_EN
            goo = (i == 0) ? oor4 : oor1;
`else
            goo = 1'b0;
`endif
            ev = 1'b0; eo = 1'b0; ed = '0; ei = 0;
            if (rst_n) begin
               ev = exp_v[i][cyc % RING];
               ed = ev ? exp_d[i][cyc % RING] : 16'h0000;
               eo = ev && exp_o[i][cyc % RING];
               for (int j = 1; j <= int'(lat_of(i)); j++)
                  ei += int'(rd_hist[(cyc + RING - j) % RING]);
            end
            check("data_valid", i, 16'(gdv), 16'(ev));
            check("data_out", i, gdo, ed);
            check("inflight", i, 16'(gin), 16'(ei));
            check("oor_err", i, 16'(goo), 16'(eo));
         end
      end
   end

   task automatic step(input bit en, input bit w, input logic [15:0] a, input logic [15:0] d);
      enable = en; wr = w; addr = a; data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   // Directed scenarios with hand-computed expectations, then random traffic.
   initial begin
      int maxinf;
      int pulses;
      bit expv;

      #1 rst_n = 1'b0;
      #1;
      check("reset_valid", 0, 16'(dv4), 16'h0000);
      check("reset_data", 0, dout4, 16'h0000);
      check("reset_inflight", 0, 16'(inf4), 16'h0000);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < 64; k++) step(1'b1, 1'b1, 16'(2 * k), 16'(k * 291 + 7));

      // Write then read the same word the next cycle.
      step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
      step(1'b1, 1'b0, 16'h0010, 16'h0000);
      check("lat1_beef_valid", 1, 16'(dv1), 16'h0001);
      check("lat1_beef_data", 1, dout1, 16'hBEEF);
      idle(3);
      check("beef_valid", 0, 16'(dv4), 16'h0001);
      check("beef_data", 0, dout4, 16'hBEEF);
      idle(1);
      check("beef_after", 0, dout4, 16'h0000);

      // Eight back-to-back reads of 1..8.
      for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 16'(2 * k), 16'(k + 1));
      maxinf = 0;
      for (int s = 0; s < 12; s++) begin
         if (s < 8) step(1'b1, 1'b0, 16'(2 * s), 16'h0000);
         else       idle(1);
         if (s < 8) begin
            check("lat1_stream_valid", 1, 16'(dv1), 16'h0001);
            check("lat1_stream_data", 1, dout1, 16'(s + 1));
         end
         expv = (s >= 3) && (s <= 10);
         check("burst_valid", 0, 16'(dv4), 16'(expv));
         if (expv) check("burst_data", 0, dout4, 16'(s - 2));
         if (int'(inf4) > maxinf) maxinf = int'(inf4);
      end
      check("burst_peak_inflight", 0, 16'(maxinf), 16'h0004);

      // Reset with three reads outstanding; array must survive, requests ignored.
      step(1'b1, 1'b0, 16'h0000, 16'h0000);
      step(1'b1, 1'b0, 16'h0002, 16'h0000);
      step(1'b1, 1'b0, 16'h0004, 16'h0000);
      idle(1);
      check("prereset_valid", 0, 16'(dv4), 16'h0001);
      check("prereset_data", 0, dout4, 16'h0001);
      check("prereset_inflight", 0, 16'(inf4), 16'h0003);
      rst_n = 1'b0;
      #1;
      check("async_valid", 0, 16'(dv4), 16'h0000);
      check("async_data", 0, dout4, 16'h0000);
      check("async_inflight", 0, 16'(inf4), 16'h0000);
      enable = 1'b1; wr = 1'b1; addr = 16'h0000; data_in = 16'hFFFF;
      @(posedge clk);
      @(posedge clk);
      #1;
      enable = 1'b0;
      rst_n = 1'b1;
      pulses = 0;
      for (int s = 0; s < 8; s++) begin
         idle(1);
         pulses += int'(dv4) + int'(dv1);
      end
      check("post_reset_pulses", 0, 16'(pulses), 16'h0000);
      step(1'b1, 1'b0, 16'h0000, 16'h0000);
      idle(3);
      check("survive_valid", 0, 16'(dv4), 16'h0001);
      check("survive_data", 0, dout4, 16'h0001);

      // Alternating read/idle: ten reads.
      maxinf = 0;
      for (int t = 0; t < 24; t++) begin
         if (t < 20 && (t % 2 == 0)) step(1'b1, 1'b0, 16'(t % 16), 16'h0000);
         else                        idle(1);
         expv = (t >= 3) && ((t - 3) % 2 == 0) && (t - 3 <= 18);
         check("alt_valid", 0, 16'(dv4), 16'(expv));
         if (int'(inf4) > maxinf) maxinf = int'(inf4);
      end
      check("alt_peak_inflight", 0, 16'(maxinf), 16'h0002);

      // Address 0x4000: out of range with checking, word 0 otherwise.
      step(1'b1, 1'b0, 16'h4000, 16'h0000);
      idle(3);
      check("hi_valid", 0, 16'(dv4), 16'h0001);
`ifdef MEM_RESP_OOR_EN
      check("hi_data", 0, dout4, 16'h0000);
      check("hi_oor", 0, 16'(oor4), 16'h0001);
`else
      check("hi_data", 0, dout4, 16'h0001);
`endif
      step(1'b1, 1'b1, 16'h4000, 16'h5A5A);
      step(1'b1, 1'b0, 16'h0000, 16'h0000);
      idle(3);
`ifdef MEM_RESP_OOR_EN
      check("hi_write_dropped", 0, dout4, 16'h0001);
`else
      check("hi_write_wraps", 0, dout4, 16'h5A5A);
`endif

      // Random traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            #1 rst_n = 1'b0;
            enable = 1'b1; wr = $urandom_range(0, 1) == 1;
            addr = 16'($urandom_range(0, 127)); data_in = 16'($urandom);
            @(posedge clk);
            @(posedge clk);
            #1 rst_n = 1'b1;
         end else begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                 {3'($urandom), 6'b000000, 6'($urandom), 1'($urandom)}, 16'($urandom));
         end
      end
      idle(8);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
